// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state type and opcode classification for alu_seq.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SGE = 4'd2;
    localparam logic [3:0] OP_SLE = 4'd3;
    localparam logic [3:0] OP_SEQ = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_XOR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_DIV = 4'd12;
    localparam logic [3:0] OP_REM = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo present the post-step register values so the caller can capture them on the done edge.
module iter_muldiv
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             busy;
    logic             mode_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opd;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mq_nxt;

    // Multiply: {acc,mq} is the product/multiplier pair. Divide: acc is the
    // partial remainder, mq shifts the dividend out and the quotient in.
    always_comb begin
        sum     = mq[0] ? ({1'b0, acc} + {1'b0, opd}) : {1'b0, acc};
        shifted = {acc, mq[WIDTH-1]};
        diff    = shifted - {1'b0, opd};
        acc_nxt = '0;
        mq_nxt  = '0;
        if (!mode_q) begin
            {acc_nxt, mq_nxt} = {sum, mq[WIDTH-1:1]};
        end else begin
            acc_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            mq_nxt  = {mq[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    assign done = busy && (cnt == '0);
    assign hi   = acc_nxt;
    assign lo   = mq_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            mode_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mq     <= '0;
            opd    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            mode_q <= mode;
            cnt    <= CNT_W'(WIDTH - 1);
            acc    <= '0;
            mq     <= a;
            opd    <= b;
        end else if (busy) begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready handshake, registered result/flags/tag and
// iterative multi-cycle MUL/DIV/REM through iter_muldiv.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf,
    output logic             dz,
    output logic             illegal
);

    state_t           state;
    logic             pend_rem;
    logic [TAG_W-1:0] pend_tag;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_dz;
    logic             alu_ill;
    logic             div_zero;
    logic             multi;
    logic             fire;
    logic             start;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign sum      = op_a + op_b;
    assign diff     = op_a - op_b;
    assign sh       = op_b[SH_W-1:0];
    assign div_zero = ((op == OP_DIV) || (op == OP_REM)) && (op_b == '0);
    assign multi    = is_multicycle(op) && !div_zero;
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign fire     = in_valid && in_ready;
    assign start    = fire && multi;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_dz  = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SGE: alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) >= $signed(op_b)};
            OP_SLE: alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) <= $signed(op_b)};
            OP_SEQ: alu_res = {{(WIDTH-1){1'b0}}, op_a == op_b};
            OP_SLL: alu_res = op_a << sh;
            OP_SRL: alu_res = op_a >> sh;
            OP_SRA: alu_res = $signed(op_a) >>> sh;
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_MUL: alu_res = '0;
            // Only reached as single-cycle ops when the divisor is zero.
            OP_DIV: begin
                alu_res = '1;
                alu_dz  = 1'b1;
            end
            OP_REM: begin
                alu_res = op_a;
                alu_dz  = 1'b1;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .mode (op != OP_MUL),
        .a    (op_a),
        .b    (op_b),
        .done (md_done),
        .hi   (md_hi),
        .lo   (md_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            out_tag   <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
            illegal   <= 1'b0;
            pend_rem  <= 1'b0;
            pend_tag  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (fire) begin
                        if (multi) begin
                            state    <= (op == OP_MUL) ? MUL : DIV;
                            pend_rem <= (op == OP_REM);
                            pend_tag <= in_tag;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            result_hi <= '0;
                            out_tag   <= in_tag;
                            ovf       <= alu_ovf;
                            dz        <= alu_dz;
                            illegal   <= alu_ill;
                        end
                    end
                end
                MUL, DIV: begin
                    // Output register is already empty here: accept required it to drain.
                    if (md_done) begin
                        out_valid <= 1'b1;
                        result    <= (state == DIV && pend_rem) ? md_hi : md_lo;
                        result_hi <= (state == MUL) ? md_hi : '0;
                        out_tag   <= pend_tag;
                        ovf       <= 1'b0;
                        dz        <= 1'b0;
                        illegal   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
